// File: rtl/fp_alu_seq.sv
// Multi-cycle floating-point add/sub/mul: IDLE -> UNPACK -> EXEC -> NORM -> DONE.
// Truncating rounding; exponent-zero operands are flushed to signed zero.
module fp_alu_seq #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [EXP_W+MAN_W:0]   a,
    input  logic [EXP_W+MAN_W:0]   b,
    input  logic [1:0]             op,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   result,
    output logic [2:0]             flags
);
    localparam int unsigned W      = 1 + EXP_W + MAN_W;
    localparam int unsigned M      = MAN_W + 1;  // significand incl. hidden bit
    localparam int unsigned A      = M + 3;      // aligned significand with guard bits
    localparam int unsigned P      = 2 * M;      // normaliser width, binary point below bit P-2
    localparam int unsigned EW     = EXP_W + 3;  // signed working exponent
    localparam int unsigned LW     = $clog2(P);
    localparam int unsigned MAX_SH = MAN_W + 3;
    localparam logic [EXP_W-1:0]     EXP_ONES = '1;
    localparam logic signed [EW-1:0] BIAS     = EW'((1 << (EXP_W - 1)) - 1);
    localparam logic [1:0] OpSub = 2'b01, OpMul = 2'b10, OpRsv = 2'b11;

    typedef enum logic [2:0] {StIdle, StUnpack, StExec, StNorm, StDone} state_e;

    state_e               state_q, state_d;
    logic                 in_ready_q, in_ready_d, out_valid_q, out_valid_d;
    logic [W-1:0]         a_q, a_d, b_q, b_d;
    logic [1:0]           op_q, op_d;
    logic                 xs_q, xs_d, ys_q, ys_d;
    logic [EXP_W-1:0]     xe_q, xe_d, ye_q, ye_d;
    logic [MAN_W-1:0]     xm_q, xm_d, ym_q, ym_d;
    logic                 spec_q, spec_d;
    logic [W-1:0]         spec_res_q, spec_res_d;
    logic [2:0]           spec_fl_q, spec_fl_d;
    logic [P-1:0]         mag_q, mag_d;
    logic signed [EW-1:0] exp_q, exp_d;
    logic                 sgn_q, sgn_d;
    logic [W-1:0]         result_q, result_d;
    logic [2:0]           flags_q, flags_d;

    // Unpack: classify operands and resolve every special-case result up front.
    logic             sa, sb, za, zb, ia, ib, na, nb, a_ge_b, swap, spec_c;
    logic [EXP_W-1:0] ea, eb, diff;
    logic [MAN_W-1:0] ma, mb;
    logic [W-1:0]     qnan, spec_res_c;
    logic [2:0]       spec_fl_c;

    always_comb begin
        sa     = a_q[W-1];
        ea     = a_q[W-2 -: EXP_W];
        ma     = a_q[MAN_W-1:0];
        sb     = b_q[W-1] ^ (op_q == OpSub);
        eb     = b_q[W-2 -: EXP_W];
        mb     = b_q[MAN_W-1:0];
        za     = (ea == '0);
        zb     = (eb == '0);
        ia     = (ea == EXP_ONES) && (ma == '0);
        ib     = (eb == EXP_ONES) && (mb == '0);
        na     = (ea == EXP_ONES) && (ma != '0);
        nb     = (eb == EXP_ONES) && (mb != '0);
        a_ge_b = {ea, ma} >= {eb, mb};
        swap   = (op_q != OpMul) && !a_ge_b;
        diff   = swap ? (eb - ea) : (ea - eb);
        qnan   = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};

        spec_c     = 1'b1;
        spec_res_c = '0;
        spec_fl_c  = 3'b000;
        if (op_q == OpRsv) begin
            spec_res_c = '0;
        end else if (na || nb) begin
            spec_res_c = qnan;
        end else if (op_q == OpMul) begin
            if ((ia && zb) || (ib && za)) spec_res_c = qnan;
            else if (ia || ib) spec_res_c = {sa ^ sb, EXP_ONES, {MAN_W{1'b0}}};
            else if (za || zb) begin
                spec_res_c = {sa ^ sb, {(W - 1){1'b0}}};
                spec_fl_c  = 3'b001;
            end else spec_c = 1'b0;
        end else begin
            if (ia && ib && (sa != sb)) spec_res_c = qnan;
            else if (ia) spec_res_c = {sa, EXP_ONES, {MAN_W{1'b0}}};
            else if (ib) spec_res_c = {sb, EXP_ONES, {MAN_W{1'b0}}};
            else if (za && zb) begin
                spec_res_c = {sa & sb, {(W - 1){1'b0}}};
                spec_fl_c  = 3'b001;
            end else if (zb) spec_res_c = a_q;
            else if (za) spec_res_c = {sb, eb, mb};
            else if (32'(diff) > MAX_SH) spec_res_c = swap ? {sb, eb, mb} : a_q;
            else spec_c = 1'b0;
        end
    end

    // Exec: x holds the larger magnitude for add/sub, so the difference never goes negative.
    logic [M-1:0]         xmf, ymf;
    logic [A-1:0]         xa, ya;
    logic [A:0]           sum;
    logic [P-1:0]         mag_c;
    logic signed [EW-1:0] exp_c;
    logic                 sgn_c;

    always_comb begin
        xmf = {1'b1, xm_q};
        ymf = {1'b1, ym_q};
        xa  = {xmf, 3'b000};
        ya  = {ymf, 3'b000} >> (xe_q - ye_q);
        sum = (xs_q == ys_q) ? ({1'b0, xa} + {1'b0, ya}) : ({1'b0, xa} - {1'b0, ya});
        if (op_q == OpMul) begin
            mag_c = P'(xmf) * P'(ymf);
            exp_c = $signed({3'b000, xe_q}) + $signed({3'b000, ye_q}) - BIAS;
            sgn_c = xs_q ^ ys_q;
        end else begin
            mag_c = P'(sum) << (M - 4);
            exp_c = $signed({3'b000, xe_q});
            sgn_c = xs_q;
        end
    end

    // Norm: leading-one detect, shift to the hidden-bit position, truncate, pack.
    logic [LW-1:0]        lead;
    logic [P-1:0]         norm;
    logic [MAN_W-1:0]     man;
    logic signed [EW-1:0] exp_n;
    logic [W-1:0]         res_c;
    logic [2:0]           fl_c;

    always_comb begin
        lead = '0;
        for (int i = 0; i < P; i++) begin
            if (mag_q[i]) lead = LW'(i);
        end
        norm  = mag_q << (LW'(P - 1) - lead);
        man   = MAN_W'(norm >> (P - 1 - MAN_W));
        exp_n = exp_q + $signed(EW'(lead)) - $signed(EW'(P - 2));
        res_c = {sgn_q, exp_n[EXP_W-1:0], man};
        fl_c  = 3'b000;
        if (spec_q) begin
            res_c = spec_res_q;
            fl_c  = spec_fl_q;
        end else if (mag_q == '0) begin
            res_c = '0;
            fl_c  = 3'b001;
        end else if (exp_n >= $signed({3'b000, EXP_ONES})) begin
            res_c = {sgn_q, EXP_ONES, {MAN_W{1'b0}}};
            fl_c  = 3'b100;
        end else if (exp_n <= 0) begin
            res_c = {sgn_q, {(W - 1){1'b0}}};
            fl_c  = 3'b011;
        end
    end

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        op_d       = op_q;
        {xs_d, xe_d, xm_d} = {xs_q, xe_q, xm_q};
        {ys_d, ye_d, ym_d} = {ys_q, ye_q, ym_q};
        spec_d     = spec_q;
        spec_res_d = spec_res_q;
        spec_fl_d  = spec_fl_q;
        mag_d      = mag_q;
        exp_d      = exp_q;
        sgn_d      = sgn_q;
        result_d   = result_q;
        flags_d    = flags_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    op_d    = op;
                    state_d = StUnpack;
                end
            end
            StUnpack: begin
                {xs_d, xe_d, xm_d} = swap ? {sb, eb, mb} : {sa, ea, ma};
                {ys_d, ye_d, ym_d} = swap ? {sa, ea, ma} : {sb, eb, mb};
                spec_d     = spec_c;
                spec_res_d = spec_res_c;
                spec_fl_d  = spec_fl_c;
                state_d    = StExec;
            end
            StExec: begin
                mag_d   = mag_c;
                exp_d   = exp_c;
                sgn_d   = sgn_c;
                state_d = StNorm;
            end
            StNorm: begin
                result_d = res_c;
                flags_d  = fl_c;
                state_d  = StDone;
            end
            StDone: begin
                if (out_ready) begin
                    flags_d = 3'b000;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        in_ready_d  = (state_d == StIdle);
        out_valid_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            {xs_q, xe_q, xm_q} <= '0;
            {ys_q, ye_q, ym_q} <= '0;
            spec_q      <= 1'b0;
            spec_res_q  <= '0;
            spec_fl_q   <= '0;
            mag_q       <= '0;
            exp_q       <= '0;
            sgn_q       <= 1'b0;
            result_q    <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            {xs_q, xe_q, xm_q} <= {xs_d, xe_d, xm_d};
            {ys_q, ye_q, ym_q} <= {ys_d, ye_d, ym_d};
            spec_q      <= spec_d;
            spec_res_q  <= spec_res_d;
            spec_fl_q   <= spec_fl_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            sgn_q       <= sgn_d;
            result_q    <= result_d;
            flags_q     <= flags_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flags     = flags_q;
endmodule

// File: tb/tb_fp_alu_seq.sv
// Bench for fp_alu_seq: vector table through a scoreboard on a single-precision
// and a half-precision instance, plus backpressure and reset-abort sequences.
module tb_fp_alu_seq;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic        iv_m, ir_m, ov_m, ordy_m;
    logic [31:0] a_m, b_m, res_m;
    logic [1:0]  op_m;
    logic [2:0]  fl_m;
    logic        iv_h, ir_h, ov_h, ordy_h;
    logic [15:0] a_h, b_h, res_h;
    logic [1:0]  op_h;
    logic [2:0]  fl_h;

    fp_alu_seq u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_m), .in_ready(ir_m), .a(a_m), .b(b_m),
        .op(op_m), .out_valid(ov_m), .out_ready(ordy_m), .result(res_m), .flags(fl_m)
    );

    fp_alu_seq #(.EXP_W(5), .MAN_W(10)) u_half (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_h), .in_ready(ir_h), .a(a_h), .b(b_h),
        .op(op_h), .out_valid(ov_h), .out_ready(ordy_h), .result(res_h), .flags(fl_h)
    );

    localparam logic [1:0] OpAdd = 2'b00, OpSub = 2'b01, OpMul = 2'b10, OpRsv = 2'b11;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  fl;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic [2:0]  fl;
    } exp_t;

    vec_t vecs[$];
    vec_t hvecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // sel picks which instance the tasks drive and observe: 0 single, 1 half.
    logic        sel;
    logic        s_ir, s_ov;
    logic [31:0] s_res;
    logic [2:0]  s_fl;
    always_comb begin
        if (sel) begin
            s_ir = ir_h; s_ov = ov_h; s_res = {16'h0000, res_h}; s_fl = fl_h;
        end else begin
            s_ir = ir_m; s_ov = ov_m; s_res = res_m; s_fl = fl_m;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic drive_in(input logic v, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b);
        if (sel) begin
            iv_h = v; op_h = op; a_h = a[15:0]; b_h = b[15:0];
        end else begin
            iv_m = v; op_m = op; a_m = a; b_m = b;
        end
    endtask

    // Present one operation, push its expectation at the accepting edge, then scramble inputs.
    task automatic issue(input string name, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] res, input logic [2:0] fl);
        int n = 0;
        while (!s_ir && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({name, "_ready_wait"}, 32'(s_ir), 32'd1);
        drive_in(1'b1, op, a, b);
        @(posedge clk);
        sb.push_back('{name, res, fl});
        #1 drive_in(1'b0, 2'($urandom), $urandom, $urandom);
    endtask

    // Wait (bounded) for out_valid; it must appear on the 4th sample after the accepting edge.
    task automatic collect();
        int   lat = 0;
        exp_t e;
        do begin
            @(negedge clk);
            lat++;
        end while (!s_ov && lat < 12);
        check("latency", 32'(lat), 32'd4);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard: got an output, expected none pending");
        end else begin
            e = sb.pop_front();
            check({e.name, "_result"}, s_res, e.res);
            check({e.name, "_flags"}, 32'(s_fl), 32'(e.fl));
        end
    endtask

    task automatic after_handshake(input string name);
        @(negedge clk);
        check({name, "_valid_pulse"}, 32'(s_ov), 32'd0);
        check({name, "_flags_idle"}, 32'(s_fl), 32'd0);
        check({name, "_ready_idle"}, 32'(s_ir), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish");
        $fatal(1);
    end

    initial begin
        vecs.push_back('{"add_1_2",     OpAdd, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000});
        vecs.push_back('{"sub_cancel",  OpSub, 32'h3FC00000, 32'h3FC00000, 32'h00000000, 3'b001});
        vecs.push_back('{"mul_2_3",     OpMul, 32'h40000000, 32'h40400000, 32'h40C00000, 3'b000});
        vecs.push_back('{"mul_ovf",     OpMul, 32'h7F000000, 32'h7F000000, 32'h7F800000, 3'b100});
        vecs.push_back('{"mul_unf",     OpMul, 32'h00800000, 32'h00800000, 32'h00000000, 3'b011});
        vecs.push_back('{"inf_m_inf",   OpAdd, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 3'b000});
        vecs.push_back('{"reserved",    OpRsv, 32'h3F800000, 32'h40000000, 32'h00000000, 3'b000});
        vecs.push_back('{"nan_in",      OpAdd, 32'h7FC00001, 32'h3F800000, 32'h7FC00000, 3'b000});
        vecs.push_back('{"inf_x_0",     OpMul, 32'h7F800000, 32'h00000000, 32'h7FC00000, 3'b000});
        vecs.push_back('{"ninf_p_1",    OpAdd, 32'hFF800000, 32'h3F800000, 32'hFF800000, 3'b000});
        vecs.push_back('{"x_p_0",       OpAdd, 32'h40490FDB, 32'h00000000, 32'h40490FDB, 3'b000});
        vecs.push_back('{"nzero_x_2",   OpMul, 32'h80000000, 32'h40000000, 32'h80000000, 3'b001});
        vecs.push_back('{"sub_2_1",     OpSub, 32'h40000000, 32'h3F800000, 32'h3F800000, 3'b000});
        vecs.push_back('{"big_diff",    OpAdd, 32'h4D000000, 32'h3F800000, 32'h4D000000, 3'b000});
        vecs.push_back('{"guard_sub",   OpSub, 32'h4C800000, 32'h3F800000, 32'h4C7FFFFF, 3'b000});
        vecs.push_back('{"trunc_add",   OpAdd, 32'h3F800000, 32'h33800000, 32'h3F800000, 3'b000});
        vecs.push_back('{"trunc_mul",   OpMul, 32'h3FFFFFFF, 32'h3FFFFFFF, 32'h407FFFFE, 3'b000});
        vecs.push_back('{"neg_add",     OpAdd, 32'hBF800000, 32'h3F000000, 32'hBF000000, 3'b000});
        vecs.push_back('{"add_ovf",     OpAdd, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b100});
        vecs.push_back('{"sub_unf",     OpSub, 32'h00FFFFFF, 32'h00800000, 32'h00000000, 3'b011});
        hvecs.push_back('{"h_add_1_1",  OpAdd, 32'h3C00, 32'h3C00, 32'h4000, 3'b000});
        hvecs.push_back('{"h_mul_2_3",  OpMul, 32'h4000, 32'h4200, 32'h4600, 3'b000});
        hvecs.push_back('{"h_cancel",   OpSub, 32'h3C00, 32'h3C00, 32'h0000, 3'b001});
        hvecs.push_back('{"h_mul_ovf",  OpMul, 32'h7800, 32'h7800, 32'h7C00, 3'b100});

        sel   = 1'b0;
        rst_n = 1'b0;
        iv_m = 1'b0; op_m = 2'b00; a_m = '0; b_m = '0; ordy_m = 1'b1;
        iv_h = 1'b0; op_h = 2'b00; a_h = '0; b_h = '0; ordy_h = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(ir_m), 32'd1);
        check("rst_out_valid", 32'(ov_m), 32'd0);
        check("rst_result", res_m, 32'd0);
        check("rst_flags", 32'(fl_m), 32'd0);
        check("rst_half_ready", 32'(ir_h), 32'd1);
        check("rst_half_result", 32'(res_h), 32'd0);

        // First edge after release accepts.
        rst_n = 1'b1;
        issue("first_after_rst", OpAdd, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
        check("accept_after_rst", 32'(s_ir), 32'd0);
        collect();
        after_handshake("first_after_rst");

        foreach (vecs[i]) begin
            issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, vecs[i].fl);
            collect();
            after_handshake(vecs[i].name);
        end

        // Backpressure: result held, new request ignored until the handshake completes.
        ordy_m = 1'b0;
        issue("bp_first", OpAdd, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
        collect();
        drive_in(1'b1, OpMul, 32'h40000000, 32'h40400000);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_hold_valid", 32'(s_ov), 32'd1);
            check("bp_hold_result", s_res, 32'h40400000);
            check("bp_hold_flags", 32'(s_fl), 32'd0);
            check("bp_in_ready", 32'(s_ir), 32'd0);
        end
        ordy_m = 1'b1;
        @(negedge clk);
        check("bp_idle_ready", 32'(s_ir), 32'd1);
        check("bp_idle_valid", 32'(s_ov), 32'd0);
        @(posedge clk);
        sb.push_back('{"bp_second", 32'h40C00000, 3'b000});
        #1 drive_in(1'b0, OpAdd, $urandom, $urandom);
        collect();
        after_handshake("bp_second");

        // Reset during EXEC abandons the operation.
        issue("aborted", OpAdd, 32'h3F800000, 32'h40000000, 32'h40400000, 3'b000);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(s_ir), 32'd1);
        check("abort_out_valid", 32'(s_ov), 32'd0);
        check("abort_result", s_res, 32'd0);
        check("abort_flags", 32'(s_fl), 32'd0);
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("abort_hold_valid", 32'(s_ov), 32'd0);
        end
        rst_n = 1'b1;
        issue("after_abort", OpAdd, 32'h3F800000, 32'h3F800000, 32'h40000000, 3'b000);
        collect();
        after_handshake("after_abort");

        sel = 1'b1;
        foreach (hvecs[i]) begin
            issue(hvecs[i].name, hvecs[i].op, hvecs[i].a, hvecs[i].b, hvecs[i].res, hvecs[i].fl);
            collect();
            after_handshake(hvecs[i].name);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
